// File: rtl/vx_nextline_prefetcher.sv
// rtl/vx_nextline_prefetcher.sv - per-bank next-line prefetch request generator
module vx_nextline_prefetcher #(
  parameter int CACHE_ID        = 0,
  parameter int BANK_ID         = 0,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int QUEUE_DEPTH     = 4,
  parameter int DEGREE          = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       miss_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] miss_addr,
  input  logic                       hit_prefetched,
  output logic                       pf_req_valid,
  output logic [LINE_ADDR_WIDTH-1:0] pf_req_addr,
  input  logic                       pf_req_ready,
  output logic                       queue_full,
  output logic [31:0]                pf_issued,
  output logic [31:0]                pf_useful,
  output logic [31:0]                pf_dropped
);

  localparam int LAW   = LINE_ADDR_WIDTH;
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int K_W   = $clog2(DEGREE + 1);

  // Reject configurations the pointer arithmetic and k counter cannot support.
  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("QUEUE_DEPTH must be a power of two and at least 2");
  end
  if (DEGREE < 1 || DEGREE > 8) begin : g_bad_degree
    $error("DEGREE must be in 1..8");
  end
  if (CACHE_ID < 0 || BANK_ID < 0) begin : g_bad_ids
    $error("CACHE_ID and BANK_ID must be non-negative");
  end

  typedef enum logic {
    ST_IDLE,
    ST_GEN
  } state_t;

  state_t           state_q, state_d;
  logic [LAW-1:0]   base_q, base_d;
  logic [K_W-1:0]   k_q, k_d;

  logic [LAW-1:0]   mem_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic [LAW-1:0]   last_q;
  logic             last_vld_q;

  logic [LAW-1:0]   cand;
  logic             cand_valid;
  logic             cand_dup;
  logic             q_full;
  logic             q_empty;
  logic             do_push;
  logic             do_pop;
  logic             drop_full;
  logic             preempt;
  logic [31:0]      drop_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Candidate is the next sequential line; address arithmetic wraps naturally.
  assign cand       = base_q + LAW'(k_q);
  assign cand_valid = (state_q == ST_GEN) && enable && !flush;
  assign q_full     = (count_q == CNT_W'(QUEUE_DEPTH));
  assign q_empty    = (count_q == '0);
  // Full is judged on the occupancy before this cycle's pop.
  assign do_push    = cand_valid && !cand_dup && !q_full;
  assign drop_full  = cand_valid && !cand_dup && q_full;
  assign do_pop     = !q_empty && pf_req_ready && !flush;
  assign preempt    = (state_q == ST_GEN) && miss_valid && enable && !flush;

  assign pf_req_valid = !q_empty;
  assign pf_req_addr  = q_empty ? '0 : mem_q[head_q];
  assign queue_full   = q_full;

  // Duplicate filter: match against every live queue entry and the last issued line.
  always_comb begin
    cand_dup = last_vld_q && (last_q == cand);
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i] == cand)) cand_dup = 1'b1;
    end
  end

  // Lost candidates: one for a full queue plus whatever a preempting miss cuts off.
  always_comb begin
    drop_inc = '0;
    if (drop_full) drop_inc = drop_inc + 32'd1;
    if (preempt)   drop_inc = drop_inc + (32'(DEGREE) - 32'(k_q));
  end

  // Next-state logic: a miss in GEN restarts the run from the new base.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    k_d     = k_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_valid && enable) begin
            state_d = ST_GEN;
            base_d  = miss_addr;
            k_d     = K_W'(1);
          end
        end
        ST_GEN: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (miss_valid) begin
            base_d = miss_addr;
            k_d    = K_W'(1);
          end else if (k_q == K_W'(DEGREE)) begin
            state_d = ST_IDLE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      k_q     <= K_W'(1);
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      k_q     <= k_d;
    end
  end

  // Prefetch FIFO plus last-issued tracking; flush wins over any handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
      vld_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (flush) begin
      vld_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      last_vld_q <= 1'b0;
    end else begin
      if (do_pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
        last_q        <= mem_q[head_q];
        last_vld_q    <= 1'b1;
      end
      if (do_push) begin
        mem_q[tail_q] <= cand;
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Saturating statistics; usefulness counts regardless of enable and flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pf_issued  <= '0;
      pf_useful  <= '0;
      pf_dropped <= '0;
    end else begin
      if (do_pop)         pf_issued  <= sat_add(pf_issued, 32'd1);
      if (hit_prefetched) pf_useful  <= sat_add(pf_useful, 32'd1);
      pf_dropped <= sat_add(pf_dropped, drop_inc);
    end
  end

endmodule

// File: tb/tb_vx_nextline_prefetcher.sv
// tb/tb_vx_nextline_prefetcher.sv - self-checking bench for vx_nextline_prefetcher
module tb_vx_nextline_prefetcher;

  localparam int LAW = 26;
  localparam int QD  = 4;
  typedef logic [LAW-1:0] addr_t;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic flush;
  logic miss_valid;
  addr_t miss_addr;
  logic hit_prefetched;
  logic pf_req_ready;

  logic        v   [2];
  addr_t       a   [2];
  logic        f   [2];
  logic [31:0] iss [2];
  logic [31:0] usf [2];
  logic [31:0] drp [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vx_nextline_prefetcher #(.LINE_ADDR_WIDTH(LAW), .QUEUE_DEPTH(QD), .DEGREE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .hit_prefetched(hit_prefetched),
    .pf_req_valid(v[0]), .pf_req_addr(a[0]), .pf_req_ready(pf_req_ready),
    .queue_full(f[0]), .pf_issued(iss[0]), .pf_useful(usf[0]), .pf_dropped(drp[0])
  );

  vx_nextline_prefetcher #(.LINE_ADDR_WIDTH(LAW), .QUEUE_DEPTH(QD), .DEGREE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .hit_prefetched(hit_prefetched),
    .pf_req_valid(v[1]), .pf_req_addr(a[1]), .pf_req_ready(pf_req_ready),
    .queue_full(f[1]), .pf_issued(iss[1]), .pf_useful(usf[1]), .pf_dropped(drp[1])
  );

  // Reference model: a queue of pending candidates per miss and a FIFO of queued lines.
  int unsigned       deg     [2];
  addr_t             mq      [2][$];
  addr_t             mp      [2][$];
  addr_t             mlast   [2];
  bit                mlast_v [2];
  longint unsigned   m_iss   [2];
  longint unsigned   m_use   [2];
  longint unsigned   m_drp   [2];

  function automatic logic [31:0] sat32(input longint unsigned x);
    return (x > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : x[31:0];
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: actual %0h required %0h", nm, i, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      mp[i].delete();
      mlast[i]   = '0;
      mlast_v[i] = 1'b0;
      m_iss[i]   = 0;
      m_use[i]   = 0;
      m_drp[i]   = 0;
    end
  endtask

  task automatic model_step(input int i);
    addr_t c;
    bit    have;
    bit    dup;
    bit    full;
    if (hit_prefetched) m_use[i]++;
    if (flush) begin
      mq[i].delete();
      mp[i].delete();
      mlast_v[i] = 1'b0;
    end else begin
      if (!enable) mp[i].delete();
      have = 1'b0;
      dup  = 1'b0;
      c    = '0;
      if (mp[i].size() > 0) begin
        c    = mp[i].pop_front();
        have = 1'b1;
      end
      if (have) begin
        for (int j = 0; j < mq[i].size(); j++) if (mq[i][j] == c) dup = 1'b1;
        if (mlast_v[i] && mlast[i] == c) dup = 1'b1;
      end
      full = (mq[i].size() == QD);
      if (have && !dup && full) m_drp[i]++;
      if (mq[i].size() > 0 && pf_req_ready) begin
        mlast[i]   = mq[i].pop_front();
        mlast_v[i] = 1'b1;
        m_iss[i]++;
      end
      if (have && !dup && !full) mq[i].push_back(c);
      if (miss_valid && enable) begin
        m_drp[i] += mp[i].size();
        mp[i].delete();
        for (int k = 1; k <= int'(deg[i]); k++) mp[i].push_back(miss_addr + addr_t'(k));
      end
    end
  endtask

  task automatic check_all();
    bit ev;
    for (int i = 0; i < 2; i++) begin
      ev = (mq[i].size() != 0);
      chk("valid",   i, v[i], ev);
      chk("addr",    i, a[i], ev ? mq[i][0] : addr_t'(0));
      chk("full",    i, f[i], mq[i].size() == QD);
      chk("issued",  i, iss[i], sat32(m_iss[i]));
      chk("useful",  i, usf[i], sat32(m_use[i]));
      chk("dropped", i, drp[i], sat32(m_drp[i]));
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    bit    miss;
    addr_t addr;
    bit    rdy;
    bit    ev;
    addr_t ea;
    int    eiss;
  } vec_t;

  vec_t tbl [8];
  longint unsigned base_drp;
  longint unsigned sv_iss [2];
  longint unsigned sv_drp [2];

  initial begin
    deg[0] = 2;
    deg[1] = 4;
    tbl[0] = '{1'b1, 26'h100,     1'b1, 1'b0, 26'h0,   0};
    tbl[1] = '{1'b0, 26'h0,       1'b1, 1'b1, 26'h101, 0};
    tbl[2] = '{1'b0, 26'h0,       1'b1, 1'b1, 26'h102, 1};
    tbl[3] = '{1'b0, 26'h0,       1'b1, 1'b0, 26'h0,   2};
    tbl[4] = '{1'b1, 26'h3FFFFFF, 1'b1, 1'b0, 26'h0,   2};
    tbl[5] = '{1'b0, 26'h0,       1'b1, 1'b1, 26'h0,   2};
    tbl[6] = '{1'b0, 26'h0,       1'b1, 1'b1, 26'h1,   3};
    tbl[7] = '{1'b0, 26'h0,       1'b1, 1'b0, 26'h0,   4};

    reset_n = 1'b0; enable = 1'b1; flush = 1'b0; miss_valid = 1'b0;
    miss_addr = '0; hit_prefetched = 1'b0; pf_req_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Sequential run and wrap-around from all-ones.
    for (int t = 0; t < 8; t++) begin
      miss_valid = tbl[t].miss; miss_addr = tbl[t].addr; pf_req_ready = tbl[t].rdy;
      tick();
      chk("tbl_valid", t, v[0], tbl[t].ev);
      if (tbl[t].ev) chk("tbl_addr", t, a[0], tbl[t].ea);
      chk("tbl_issued", t, iss[0], tbl[t].eiss);
    end

    // Overlapping misses: duplicate 0x102 filtered, only 0x103 added.
    miss_valid = 1'b0; pf_req_ready = 1'b0;
    miss_valid = 1'b1; miss_addr = 26'h100; tick();
    miss_valid = 1'b0; tick(); tick();
    miss_valid = 1'b1; miss_addr = 26'h101; tick();
    miss_valid = 1'b0; tick(); tick();
    chk("dup_valid", 0, v[0], 1);
    chk("dup_head", 0, a[0], 26'h101);
    chk("dup_full", 0, f[0], 0);
    chk("dup_dropped", 0, drp[0], 0);
    pf_req_ready = 1'b1;
    tick(); chk("dup_order", 1, a[0], 26'h102);
    tick(); chk("dup_order", 2, a[0], 26'h103);
    tick(); chk("dup_empty", 0, v[0], 0);

    // Fill to full, two drops, then drain in order.
    pf_req_ready = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      miss_valid = 1'b1; miss_addr = addr_t'(m * 16); tick();
      miss_valid = 1'b0; tick(); tick();
    end
    chk("fill_full", 0, f[0], 1);
    chk("fill_dropped", 0, drp[0], 2);
    chk("fill_head", 0, a[0], 26'h11);
    pf_req_ready = 1'b1;
    tick(); chk("drain_order", 1, a[0], 26'h12);
    tick(); chk("drain_order", 2, a[0], 26'h21);
    tick(); chk("drain_order", 3, a[0], 26'h22);
    tick(); chk("drain_empty", 0, v[0], 0);

    // Preemption on the DEGREE=4 instance.
    flush = 1'b1; tick(); flush = 1'b0;
    pf_req_ready = 1'b1;
    base_drp = m_drp[1];
    miss_valid = 1'b1; miss_addr = 26'h40; tick();
    miss_valid = 1'b0; tick(); chk("pre_head", 0, a[1], 26'h41);
    miss_valid = 1'b1; miss_addr = 26'h80; tick(); chk("pre_head", 1, a[1], 26'h42);
    miss_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(); chk("pre_head", k + 1, a[1], addr_t'(26'h80 + k));
    end
    tick(); chk("pre_empty", 1, v[1], 0);
    chk("pre_dropped", 1, drp[1], sat32(base_drp + 2));

    // Flush with pending entries, then asynchronous reset.
    pf_req_ready = 1'b0;
    miss_valid = 1'b1; miss_addr = 26'h200; tick();
    miss_valid = 1'b0; tick(); tick();
    chk("preflush_valid", 0, v[0], 1);
    for (int i = 0; i < 2; i++) begin sv_iss[i] = m_iss[i]; sv_drp[i] = m_drp[i]; end
    flush = 1'b1; pf_req_ready = 1'b1; tick(); flush = 1'b0; pf_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("flush_valid", i, v[i], 0);
      chk("flush_issued", i, iss[i], sat32(sv_iss[i]));
      chk("flush_dropped", i, drp[i], sat32(sv_drp[i]));
    end
    hit_prefetched = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, v[i], 0);
      chk("rst_addr", i, a[i], 0);
      chk("rst_full", i, f[i], 0);
      chk("rst_issued", i, iss[i], 0);
      chk("rst_useful", i, usf[i], 0);
      chk("rst_dropped", i, drp[i], 0);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    hit_prefetched = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      miss_valid     = ($urandom_range(0, 9) < 3);
      miss_addr      = ($urandom_range(0, 7) == 0) ? addr_t'(26'h3FFFFFF - $urandom_range(0, 3))
                                                   : addr_t'($urandom_range(0, 31));
      pf_req_ready   = $urandom_range(0, 1);
      enable         = ($urandom_range(0, 9) != 0);
      flush          = ($urandom_range(0, 31) == 0);
      hit_prefetched = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
